// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the time-multiplexed seven-segment display.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g} with a as the MSB.
package seg_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    // Returns {pm, hour_bcd_12h}; only meaningful for a valid 24h BCD hour.
    function automatic logic [8:0] hour24_to_12(input logic [7:0] bcd);
        logic [7:0] bin;
        logic [7:0] h12;
        logic [8:0] result;
        bin = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
        h12 = bin - 8'd12;
        if (bin == 8'd0) begin
            result = {1'b0, 8'h12};
        end else if (bin < 8'd12) begin
            result = {1'b0, bcd};
        end else if (bin == 8'd12) begin
            result = {1'b1, 8'h12};
        end else if (h12 >= 8'd10) begin
            result = {1'b1, 4'd1, h12[3:0] - 4'd10};
        end else begin
            result = {1'b1, 4'd0, h12[3:0]};
        end
        return result;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] bcd, input logic [7:0] max);
        return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9) && (bcd <= max);
    endfunction

endpackage

// File: rtl/seg7_bcd_digit.sv
// Combinational BCD to seven-segment decoder with blanking.
// Codes above 9 decode to a dash, which the top uses to flag invalid frames.
module seg7_bcd_digit
    import seg_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else if (i_bcd <= 4'd9) begin
            o_seg = SEG_DIGIT[i_bcd];
        end
    end

endmodule

// File: rtl/seg_time_display_scan.sv
// Scanned common-anode HH:MM / HH:MM:SS driver with 12h conversion, blinking,
// invalid-input dashes and ghost suppression. Outputs are registered.
module seg_time_display_scan
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GHOST_CYCLES = 2,
    parameter int BLINK_DIV    = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            hour_bcd,
    input  logic [7:0]            min_bcd,
    input  logic [7:0]            sec_bcd,
    input  logic                  mode_12h,
    input  logic                  blink_en,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  pm
);

    localparam int PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW     = $clog2(NUM_DIGITS);
    localparam int FW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HT_IDX = NUM_DIGITS - 1;
    localparam int HO_IDX = NUM_DIGITS - 2;
    localparam int MO_IDX = (NUM_DIGITS == 6) ? 2 : 0;

    logic [PW-1:0]           r_prescaler;
    logic [DW-1:0]           r_digit_idx;
    logic [FW-1:0]           r_frame_cnt;
    logic                    r_blink_phase;
    logic [7:0]              r_hour;
    logic [7:0]              r_min;
    logic [7:0]              r_sec;
    logic                    r_mode_12h;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_pm;

    logic                    w_tick;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [8:0]              w_conv;
    logic [7:0]              w_hour_disp;
    logic [4*NUM_DIGITS-1:0] w_digit_vec;
    logic                    w_sec_ok;
    logic                    w_valid;
    logic                    w_pm;
    logic [3:0]              w_nib;
    logic                    w_blink_blank;
    logic                    w_lead_blank;
    logic [3:0]              w_dec_bcd;
    logic                    w_dec_blank;
    logic [6:0]              w_seg;
    logic                    w_dp_low;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_tick = (r_prescaler == PW'(REFRESH_DIV - 1));
    assign w_wrap = w_tick && (r_digit_idx == DW'(NUM_DIGITS - 1));

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
        assign w_onehot[gi] = (r_digit_idx == DW'(gi));
    end

    assign w_conv      = hour24_to_12(r_hour);
    assign w_hour_disp = r_mode_12h ? w_conv[7:0] : r_hour;

    if (NUM_DIGITS == 6) begin : g_six
        assign w_digit_vec = {w_hour_disp, r_min, r_sec};
        assign w_sec_ok    = bcd_valid(r_sec, 8'h59);
    end else begin : g_four
        logic [7:0] w_unused_sec;
        assign w_unused_sec = r_sec;
        assign w_digit_vec  = {w_hour_disp, r_min};
        assign w_sec_ok     = 1'b1;
    end

    assign w_valid = bcd_valid(r_hour, 8'h23) && bcd_valid(r_min, 8'h59) && w_sec_ok;
    assign w_pm    = w_valid && r_mode_12h && w_conv[8];

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_onehot[i]) begin
                w_nib = w_digit_vec[4*i +: 4];
            end
        end
    end

    assign w_blink_blank = blink_en && r_blink_phase && (|(blink_mask & w_onehot));
    assign w_lead_blank  = r_mode_12h && w_onehot[HT_IDX] && (w_hour_disp[7:4] == 4'd0);

    // Invalid frames feed a non-BCD code so the decoder produces the dash.
    assign w_dec_bcd   = w_valid ? w_nib : 4'hF;
    assign w_dec_blank = w_blink_blank || (w_valid && w_lead_blank);

    seg7_bcd_digit u_digit (
        .i_bcd   (w_dec_bcd),
        .i_blank (w_dec_blank),
        .o_seg   (w_seg)
    );

    assign w_dp_low = w_valid && !w_blink_blank &&
                      (w_onehot[HO_IDX] ||
                       ((NUM_DIGITS == 6) && w_onehot[MO_IDX]) ||
                       (w_pm && w_onehot[0]));

    assign w_an_next = (r_prescaler < PW'(GHOST_CYCLES)) ? '1 : ~w_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler   <= '0;
            r_digit_idx   <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_hour        <= '0;
            r_min         <= '0;
            r_sec         <= '0;
            r_mode_12h    <= 1'b0;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_an          <= '1;
            r_pm          <= 1'b0;
        end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + PW'(1);
            if (w_tick) begin
                r_digit_idx <= w_wrap ? '0 : r_digit_idx + DW'(1);
            end
            // Whole-frame capture at the wrap keeps a frame from tearing.
            if (w_wrap) begin
                r_hour     <= hour_bcd;
                r_min      <= min_bcd;
                r_sec      <= sec_bcd;
                r_mode_12h <= mode_12h;
                if (r_frame_cnt == FW'(BLINK_DIV - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
            end
            r_seg <= w_seg;
            r_dp  <= !w_dp_low;
            r_an  <= w_an_next;
            r_pm  <= w_pm;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;
    assign pm  = r_pm;

endmodule
